// File: rtl/mult_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_wb_arbiter_if
//   Bundles the buses around the multiplier writeback arbiter:
//     - multiplier result stream (mult_valid_i, mult_rd_addr_i, mult_rd_data_i)
//       and the multiplier's in-flight destination flags (mult_flags_i)
//     - main-pipeline writeback (wb_valid_i, wb_rd_addr_i, wb_rd_data_i)
//     - ID-stage operand/destination info (id_*) and the stall reply (stall_o)
//     - register-file write port (rf_we_o, rf_waddr_o, rf_wdata_o)
//     - status (pending_flags_o, fifo_count_o, credits_o)
//   Optional macro MULT_WB_FWD_EN adds the forwarding outputs
//   fwd_rs1_hit_o/fwd_rs2_hit_o and fwd_rs1_data_o/fwd_rs2_data_o.
//   Modports: slave = the arbiter, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface mult_wb_arbiter_if #(
    parameter int CNT_W = 3
);
    logic             mult_valid_i;
    logic [4:0]       mult_rd_addr_i;
    logic [31:0]      mult_rd_data_i;
    logic [31:0]      mult_flags_i;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_addr_i;
    logic [31:0]      wb_rd_data_i;
    logic             id_valid_i;
    logic             id_is_mult_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic [4:0]       id_rd_addr_i;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic             stall_o;
    logic [31:0]      pending_flags_o;
    logic [CNT_W-1:0] fifo_count_o;
    logic [CNT_W-1:0] credits_o;
`ifdef MULT_WB_FWD_EN
    logic             fwd_rs1_hit_o;
    logic             fwd_rs2_hit_o;
    logic [31:0]      fwd_rs1_data_o;
    logic [31:0]      fwd_rs2_data_o;
`endif

    modport slave (
`ifdef MULT_WB_FWD_EN
        output fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o,
`endif
        input  mult_valid_i, mult_rd_addr_i, mult_rd_data_i, mult_flags_i,
        input  wb_valid_i, wb_rd_addr_i, wb_rd_data_i,
        input  id_valid_i, id_is_mult_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output stall_o, pending_flags_o, fifo_count_o, credits_o
    );

    modport master (
`ifdef MULT_WB_FWD_EN
        input  fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o,
`endif
        output mult_valid_i, mult_rd_addr_i, mult_rd_data_i, mult_flags_i,
        output wb_valid_i, wb_rd_addr_i, wb_rd_data_i,
        output id_valid_i, id_is_mult_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  stall_o, pending_flags_o, fifo_count_o, credits_o
    );
endinterface

// File: rtl/mult_wb_arbiter.sv
// ---------------------------------------------------------------------------
// mult_wb_arbiter
//   Merges multiplier results and main-pipeline writebacks onto the single
//   register-file write port. Main writebacks have priority; multiplier
//   results that lose are parked in an in-order FIFO (the multiplier cannot
//   stall). An issue-credit counter keeps the FIFO from overflowing, and the
//   block generates the ID-stage stall for RAW/WAW hazards on destinations
//   still inside the multiplier or waiting here.
//
//   Ports:
//     clk, rst  clock, synchronous active-high reset
//     bus       mult_wb_arbiter_if.slave (see interface for signal list)
//
//   Parameters:
//     FIFO_DEPTH  result buffer entries (power of 2, >= 2)
//     CNT_W       width of count/credit fields (>= log2(FIFO_DEPTH)+1)
//
//   Optional macro MULT_WB_FWD_EN: RAW hits on entries held here (FIFO or
//   output stage) are forwarded combinationally instead of stalling.
// ---------------------------------------------------------------------------
module mult_wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic              clk,
    input logic              rst,
    mult_wb_arbiter_if.slave bus
);
    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Result buffer: data storage is not reset, only the pointers/count.
    logic [4:0]       fifo_addr [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] credits;

    // Output stage
    logic             out_we_p1;
    logic             out_mult_p1;
    logic [4:0]       out_waddr_p1;
    logic [31:0]      out_wdata_p1;

    // Arbitration decisions for the current cycle
    logic             wb_go_p0;
    logic             mult_go_p0;
    logic             fifo_ne_p0;
    logic             fifo_full_p0;
    logic             pop_p0;
    logic             bypass_p0;
    logic             push_req_p0;
    logic             push_p0;
    logic             push_drop_p0;
    logic             emit_p0;
    logic             credit_inc_p0;
    logic             credit_dec_p0;

    logic [FIFO_DEPTH-1:0] entry_vld;
    logic [31:0]           pending_flags;
    logic [31:0]           raw_flags;
    logic [31:0]           waw_flags;
    logic                  stall;

    function automatic logic [31:0] addr_flag(input logic [4:0] a);
        return 32'd1 << a;
    endfunction

    // Saturating credit update; a simultaneous return and issue cancel out.
    function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] cur,
                                                     input logic             inc,
                                                     input logic             dec);
        if (inc && dec) return cur;
        if (inc)        return (cur == DEPTH_C) ? cur : cur + 1'b1;
        if (dec)        return (cur == '0) ? cur : cur - 1'b1;
        return cur;
    endfunction

    // ---- stage p0: arbitration ----
    always_comb begin
        wb_go_p0      = bus.wb_valid_i && (bus.wb_rd_addr_i != 5'd0);
        mult_go_p0    = bus.mult_valid_i && (bus.mult_rd_addr_i != 5'd0);
        fifo_ne_p0    = (count != '0);
        fifo_full_p0  = (count == DEPTH_C);
        pop_p0        = !wb_go_p0 && fifo_ne_p0;
        // Bypass only when the FIFO is empty, so ordering is preserved.
        bypass_p0     = !wb_go_p0 && !fifo_ne_p0 && mult_go_p0;
        push_req_p0   = mult_go_p0 && !bypass_p0;
        // A pop in the same cycle frees the slot the push lands in.
        push_p0       = push_req_p0 && (!fifo_full_p0 || pop_p0);
        push_drop_p0  = push_req_p0 && fifo_full_p0 && !pop_p0;
        emit_p0       = wb_go_p0 || pop_p0 || bypass_p0;
        credit_inc_p0 = pop_p0 || bypass_p0;
        credit_dec_p0 = bus.id_valid_i && bus.id_is_mult_i &&
                        (bus.id_rd_addr_i != 5'd0) && !stall;
    end

    // Pending destinations: live FIFO entries plus a mult write in the output stage.
    always_comb begin
        entry_vld     = '0;
        pending_flags = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_vld[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
            if (entry_vld[i]) pending_flags = pending_flags | addr_flag(fifo_addr[i]);
        end
        if (out_we_p1 && out_mult_p1) pending_flags = pending_flags | addr_flag(out_waddr_p1);
    end

    // Hazard detection
    always_comb begin
`ifdef MULT_WB_FWD_EN
        // Hits on locally held entries are forwarded, so only in-flight
        // multiplier destinations cause a RAW stall.
        raw_flags = bus.mult_flags_i;
`else
        raw_flags = bus.mult_flags_i | pending_flags;
`endif
        waw_flags = bus.mult_flags_i | pending_flags;
        stall = bus.id_valid_i && (
                    (bus.id_is_mult_i && (bus.id_rd_addr_i != 5'd0) && (credits == '0)) ||
                    ((bus.id_rs1_addr_i != 5'd0) && raw_flags[bus.id_rs1_addr_i]) ||
                    ((bus.id_rs2_addr_i != 5'd0) && raw_flags[bus.id_rs2_addr_i]) ||
                    ((bus.id_rd_addr_i  != 5'd0) && waw_flags[bus.id_rd_addr_i]));
    end

`ifdef MULT_WB_FWD_EN
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    // WAW stalling keeps at most one held entry per rd, so first match is the only match.
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i] && (fifo_addr[i] == bus.id_rs1_addr_i)) fwd1_data = fifo_data[i];
            if (entry_vld[i] && (fifo_addr[i] == bus.id_rs2_addr_i)) fwd2_data = fifo_data[i];
        end
        if (out_we_p1 && out_mult_p1 && (out_waddr_p1 == bus.id_rs1_addr_i)) fwd1_data = out_wdata_p1;
        if (out_we_p1 && out_mult_p1 && (out_waddr_p1 == bus.id_rs2_addr_i)) fwd2_data = out_wdata_p1;
    end

    assign bus.fwd_rs1_hit_o  = (bus.id_rs1_addr_i != 5'd0) && pending_flags[bus.id_rs1_addr_i];
    assign bus.fwd_rs2_hit_o  = (bus.id_rs2_addr_i != 5'd0) && pending_flags[bus.id_rs2_addr_i];
    assign bus.fwd_rs1_data_o = fwd1_data;
    assign bus.fwd_rs2_data_o = fwd2_data;
`endif

    // ---- stage p1: FIFO, credits and output register ----
    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_addr[wr_ptr] <= bus.mult_rd_addr_i;
            fifo_data[wr_ptr] <= bus.mult_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            credits <= DEPTH_C;
        end else begin
            if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
            if (push_p0) wr_ptr <= wr_ptr + 1'b1;
            case ({push_p0, pop_p0})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            credits <= credit_next(credits, credit_inc_p0, credit_dec_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_we_p1    <= 1'b0;
            out_mult_p1  <= 1'b0;
            out_waddr_p1 <= '0;
            out_wdata_p1 <= '0;
        end else begin
            out_we_p1   <= emit_p0;
            out_mult_p1 <= pop_p0 || bypass_p0;
            // Address/data hold their last value on idle cycles.
            if (wb_go_p0) begin
                out_waddr_p1 <= bus.wb_rd_addr_i;
                out_wdata_p1 <= bus.wb_rd_data_i;
            end else if (pop_p0) begin
                out_waddr_p1 <= fifo_addr[rd_ptr];
                out_wdata_p1 <= fifo_data[rd_ptr];
            end else if (bypass_p0) begin
                out_waddr_p1 <= bus.mult_rd_addr_i;
                out_wdata_p1 <= bus.mult_rd_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!push_drop_p0)
                else $error("mult_wb_arbiter: result for rd=%0d dropped, buffer full",
                            bus.mult_rd_addr_i);
        end
    end
`endif

    assign bus.rf_we_o         = out_we_p1;
    assign bus.rf_waddr_o      = out_waddr_p1;
    assign bus.rf_wdata_o      = out_wdata_p1;
    assign bus.stall_o         = stall;
    assign bus.pending_flags_o = pending_flags;
    assign bus.fifo_count_o    = count;
    assign bus.credits_o       = credits;
endmodule

// File: tb/tb_mult_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_wb_arbiter
//   Directed bench for mult_wb_arbiter: a table of combinational stall
//   vectors plus hand-written sequences for bypass, FIFO ordering, credit
//   exhaustion and mid-operation reset. Builds with or without
//   MULT_WB_FWD_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_wb_arbiter;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_wb_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mult_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] flags;
        logic        id_valid;
        logic        is_mult;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        exp_stall;
    } stall_vec_t;

    stall_vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mult_valid_i   = 1'b0;
        bus.mult_rd_addr_i = 5'd0;
        bus.mult_rd_data_i = 32'd0;
        bus.mult_flags_i   = 32'd0;
        bus.wb_valid_i     = 1'b0;
        bus.wb_rd_addr_i   = 5'd0;
        bus.wb_rd_data_i   = 32'd0;
        bus.id_valid_i     = 1'b0;
        bus.id_is_mult_i   = 1'b0;
        bus.id_rs1_addr_i  = 5'd0;
        bus.id_rs2_addr_i  = 5'd0;
        bus.id_rd_addr_i   = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic mult_in(input logic [4:0] a, input logic [31:0] d);
        bus.mult_valid_i   = 1'b1;
        bus.mult_rd_addr_i = a;
        bus.mult_rd_data_i = d;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0200, 1'b1, 1'b0, 5'd0,  5'd9,  5'd0,  1'b1};
        vecs[1] = '{32'h0000_0001, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0};
        vecs[2] = '{32'h0000_0200, 1'b1, 1'b0, 5'd0,  5'd0,  5'd9,  1'b1};
        vecs[3] = '{32'h0000_0200, 1'b0, 1'b0, 5'd9,  5'd9,  5'd9,  1'b0};
        vecs[4] = '{32'h0000_0200, 1'b1, 1'b0, 5'd8,  5'd10, 5'd11, 1'b0};
        vecs[5] = '{32'h8000_0000, 1'b1, 1'b0, 5'd31, 5'd0,  5'd0,  1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0};
        vecs[7] = '{32'h0000_0000, 1'b1, 1'b1, 5'd1,  5'd2,  5'd3,  1'b0};
        vecs[8] = '{32'h0000_0010, 1'b1, 1'b1, 5'd4,  5'd0,  5'd3,  1'b1};

        // Reset state
        do_reset();
        chk("reset_we",      {31'd0, bus.rf_we_o}, 32'd0);
        chk("reset_waddr",   {27'd0, bus.rf_waddr_o}, 32'd0);
        chk("reset_wdata",   bus.rf_wdata_o, 32'd0);
        chk("reset_credits", 32'(bus.credits_o), 32'd4);
        chk("reset_count",   32'(bus.fifo_count_o), 32'd0);
        chk("reset_pending", bus.pending_flags_o, 32'd0);
        chk("reset_stall",   {31'd0, bus.stall_o}, 32'd0);

        // Combinational stall table (no pending entries, credits available)
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.mult_flags_i  = vecs[i].flags;
            bus.id_valid_i    = vecs[i].id_valid;
            bus.id_is_mult_i  = vecs[i].is_mult;
            bus.id_rs1_addr_i = vecs[i].rs1;
            bus.id_rs2_addr_i = vecs[i].rs2;
            bus.id_rd_addr_i  = vecs[i].rd;
            #1;
            chk($sformatf("stall_vec%0d", i), {31'd0, bus.stall_o}, {31'd0, vecs[i].exp_stall});
        end
        // Table vectors may have issued mults; start the sequences clean.
        do_reset();

        // Direct bypass of a lone mult result
        mult_in(5'd5, 32'h1234_5678);
        step();
        bus.mult_valid_i = 1'b0;
        chk("byp_we",      {31'd0, bus.rf_we_o}, 32'd1);
        chk("byp_waddr",   {27'd0, bus.rf_waddr_o}, 32'd5);
        chk("byp_wdata",   bus.rf_wdata_o, 32'h1234_5678);
        chk("byp_count",   32'(bus.fifo_count_o), 32'd0);
        chk("byp_pending", bus.pending_flags_o, 32'h0000_0020);
        step();
        chk("byp_idle_we",    {31'd0, bus.rf_we_o}, 32'd0);
        chk("byp_idle_waddr", {27'd0, bus.rf_waddr_o}, 32'd5);
        chk("byp_idle_pend",  bus.pending_flags_o, 32'd0);

        // Main wb wins; mult results queue then drain in order
        bus.wb_valid_i   = 1'b1;
        bus.wb_rd_addr_i = 5'd7;
        bus.wb_rd_data_i = 32'h0000_AAAA;
        mult_in(5'd3, 32'h0000_0033);
        step();
        chk("q1_waddr",   {27'd0, bus.rf_waddr_o}, 32'd7);
        chk("q1_wdata",   bus.rf_wdata_o, 32'h0000_AAAA);
        chk("q1_count",   32'(bus.fifo_count_o), 32'd1);
        chk("q1_pending", bus.pending_flags_o, 32'h0000_0008);
        mult_in(5'd4, 32'h0000_0044);
        step();
        chk("q2_count",   32'(bus.fifo_count_o), 32'd2);
        chk("q2_pending", bus.pending_flags_o, 32'h0000_0018);
        bus.mult_valid_i  = 1'b0;
        bus.id_valid_i    = 1'b1;
        bus.id_rs1_addr_i = 5'd3;
        #1;
`ifdef MULT_WB_FWD_EN
        chk("raw_fifo_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("raw_fifo_hit",   {31'd0, bus.fwd_rs1_hit_o}, 32'd1);
        chk("raw_fifo_data",  bus.fwd_rs1_data_o, 32'h0000_0033);
`else
        chk("raw_fifo_stall", {31'd0, bus.stall_o}, 32'd1);
`endif
        bus.id_valid_i    = 1'b0;
        bus.id_rs1_addr_i = 5'd0;
        bus.wb_valid_i    = 1'b0;
        mult_in(5'd8, 32'h0000_0088);   // push and pop together
        step();
        bus.mult_valid_i = 1'b0;
        chk("d1_waddr",   {27'd0, bus.rf_waddr_o}, 32'd3);
        chk("d1_wdata",   bus.rf_wdata_o, 32'h0000_0033);
        chk("d1_count",   32'(bus.fifo_count_o), 32'd2);
        chk("d1_pending", bus.pending_flags_o, 32'h0000_0118);
        step();
        chk("d2_waddr",   {27'd0, bus.rf_waddr_o}, 32'd4);
        chk("d2_wdata",   bus.rf_wdata_o, 32'h0000_0044);
        chk("d2_count",   32'(bus.fifo_count_o), 32'd1);
        chk("d2_pending", bus.pending_flags_o, 32'h0000_0110);
        step();
        chk("d3_waddr",   {27'd0, bus.rf_waddr_o}, 32'd8);
        chk("d3_wdata",   bus.rf_wdata_o, 32'h0000_0088);
        chk("d3_count",   32'(bus.fifo_count_o), 32'd0);
        chk("d3_pending", bus.pending_flags_o, 32'h0000_0100);
        step();
        chk("d4_we",      {31'd0, bus.rf_we_o}, 32'd0);
        chk("d4_pending", bus.pending_flags_o, 32'd0);
        chk("d4_credits", 32'(bus.credits_o), 32'd4);

        // Credit exhaustion with the write port held busy
        bus.wb_valid_i   = 1'b1;
        bus.wb_rd_addr_i = 5'd7;
        bus.wb_rd_data_i = 32'h0000_0777;
        for (int k = 1; k <= 4; k++) begin
            bus.id_valid_i   = 1'b1;
            bus.id_is_mult_i = 1'b1;
            bus.id_rd_addr_i = 5'(k);
            #1;
            chk($sformatf("issue%0d_stall", k), {31'd0, bus.stall_o}, 32'd0);
            step();
            chk($sformatf("issue%0d_credits", k), 32'(bus.credits_o), 32'(4 - k));
        end
        bus.id_rd_addr_i = 5'd5;
        #1;
        chk("cred0_stall", {31'd0, bus.stall_o}, 32'd1);
        bus.id_is_mult_i = 1'b0;
        #1;
        chk("cred0_nonmult", {31'd0, bus.stall_o}, 32'd0);
        bus.id_is_mult_i = 1'b1;
        mult_in(5'd1, 32'h0000_1111);
        step();
        chk("cred0_count",    32'(bus.fifo_count_o), 32'd1);
        chk("cred0_credits",  32'(bus.credits_o), 32'd0);
        chk("cred0_stall2",   {31'd0, bus.stall_o}, 32'd1);
        bus.mult_valid_i = 1'b0;
        bus.wb_valid_i   = 1'b0;
        step();
        chk("ret_waddr",   {27'd0, bus.rf_waddr_o}, 32'd1);
        chk("ret_wdata",   bus.rf_wdata_o, 32'h0000_1111);
        chk("ret_credits", 32'(bus.credits_o), 32'd1);
        chk("ret_stall",   {31'd0, bus.stall_o}, 32'd0);
        // Return (bypass) and issue in the same cycle
        bus.id_rd_addr_i = 5'd6;
        mult_in(5'd2, 32'h0000_2222);
        #1;
        chk("both_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        idle();
        chk("both_credits", 32'(bus.credits_o), 32'd1);
        chk("both_waddr",   {27'd0, bus.rf_waddr_o}, 32'd2);
        chk("both_count",   32'(bus.fifo_count_o), 32'd0);

        // Fill three entries, check hazards, then reset mid-operation
        bus.wb_valid_i   = 1'b1;
        bus.wb_rd_addr_i = 5'd7;
        bus.wb_rd_data_i = 32'h0000_0777;
        mult_in(5'd6, 32'h0000_CAFE);
        step();
        mult_in(5'd11, 32'h0000_0B0B);
        step();
        mult_in(5'd12, 32'h0000_0C0C);
        step();
        bus.mult_valid_i = 1'b0;
        chk("fill_count",   32'(bus.fifo_count_o), 32'd3);
        chk("fill_pending", bus.pending_flags_o, 32'h0000_1840);
        bus.id_valid_i    = 1'b1;
        bus.id_rs1_addr_i = 5'd6;
        bus.id_rs2_addr_i = 5'd12;
        #1;
`ifdef MULT_WB_FWD_EN
        chk("fwd_stall",   {31'd0, bus.stall_o}, 32'd0);
        chk("fwd_hit1",    {31'd0, bus.fwd_rs1_hit_o}, 32'd1);
        chk("fwd_data1",   bus.fwd_rs1_data_o, 32'h0000_CAFE);
        chk("fwd_hit2",    {31'd0, bus.fwd_rs2_hit_o}, 32'd1);
        chk("fwd_data2",   bus.fwd_rs2_data_o, 32'h0000_0C0C);
`else
        chk("fill_raw_stall", {31'd0, bus.stall_o}, 32'd1);
`endif
        bus.id_rs1_addr_i = 5'd0;
        bus.id_rs2_addr_i = 5'd0;
        bus.id_rd_addr_i  = 5'd11;
        #1;
        chk("fill_waw_stall", {31'd0, bus.stall_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_count",   32'(bus.fifo_count_o), 32'd0);
        chk("mrst_credits", 32'(bus.credits_o), 32'd4);
        chk("mrst_we",      {31'd0, bus.rf_we_o}, 32'd0);
        chk("mrst_waddr",   {27'd0, bus.rf_waddr_o}, 32'd0);
        chk("mrst_pending", bus.pending_flags_o, 32'd0);
        rst = 1'b0;
        idle();
        step();
        chk("post_we",    {31'd0, bus.rf_we_o}, 32'd0);
        chk("post_count", 32'(bus.fifo_count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
